// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - hazard controller signal bundle; counters exist only with PIPE_PERF_CNT_EN
interface pipe_hazard_if #(parameter int CNT_W = 32);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic [4:0]       rd_ex;
  logic             mem_read_ex;
  logic             branch_taken_ex;
  logic             halt_id;
  logic             resume_req;
  logic             dmem_req_mem;
  logic             dmem_ready_mem;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, halt_id, resume_req, dmem_req_mem, dmem_ready_mem,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, halted
`ifdef PIPE_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport slave (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, halt_id, resume_req, dmem_req_mem, dmem_ready_mem,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, halted
`ifdef PIPE_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32I 5-stage pipeline enable/flush sequencer; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  pipe_hazard_if.master hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;
  logic       halted_q;
  logic       mem_busy;
  logic       load_use;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic       redirect;

  assign mem_busy = hz.dmem_req_mem & ~hz.dmem_ready_mem;
  assign load_use = hz.mem_read_ex & (hz.rd_ex != 5'd0) &
                    ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) |
                     (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      halted_q  <= (state_nxt == HALTED);
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    redirect     = 1'b0;
    state_nxt    = state;
    drain_nxt    = drain_cnt;

    unique case (state)
      // MEM_WAIT with no request pending simply falls through to the RUN rules
      RUN, MEM_WAIT: begin
        state_nxt = RUN;
        if (mem_busy) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          mem_wb_flush = 1'b1;
          state_nxt    = MEM_WAIT;
        end else if (hz.branch_taken_ex) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          redirect    = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (hz.halt_id) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          drain_nxt   = 2'd3;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (mem_busy) begin
          {id_ex_en, ex_mem_en, mem_wb_en} = 3'b0;
          mem_wb_flush = 1'b1;
        end else begin
          drain_nxt = drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state_nxt = HALTED;
        end
      end
      HALTED: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
        if (hz.resume_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    // Reset overrides everything so the pipeline fills with bubbles before the first edge
    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = 3'b111;
      redirect = 1'b0;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.halted       = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_evt;

  assign stall_evt = ~pc_en & (state != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (redirect && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_if #(.CNT_W(CNT_W)) hz ();
  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles of drain left (0 = not draining), halted flag, counters
  int     m_drain_left;
  bit     m_halt;
  longint m_stall, m_flush;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    hz.rs1_id = 0; hz.rs2_id = 0; hz.rs1_used_id = 0; hz.rs2_used_id = 0;
    hz.rd_ex = 0; hz.mem_read_ex = 0; hz.branch_taken_ex = 0; hz.halt_id = 0;
    hz.resume_req = 0; hz.dmem_req_mem = 0; hz.dmem_ready_mem = 0;
  endtask

  task automatic model_reset();
    m_drain_left = 0; m_halt = 0; m_stall = 0; m_flush = 0;
  endtask

  // expected {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,mem_wb flush}; advances the model one edge
  task automatic model_step(output logic [7:0] exp);
    bit busy, lu;
    logic [4:0] en;
    logic [2:0] fl;
    busy = hz.dmem_req_mem && !hz.dmem_ready_mem;
    lu = hz.mem_read_ex && hz.rd_ex != 0 &&
         ((hz.rs1_used_id && hz.rs1_id == hz.rd_ex) || (hz.rs2_used_id && hz.rs2_id == hz.rd_ex));
    en = 5'b11111; fl = 3'b000;
    if (m_halt) begin
      en = 5'b00000;
      if (hz.resume_req) m_halt = 0;
    end else if (m_drain_left > 0) begin
      en = 5'b00111; fl = 3'b010;
      if (busy) begin
        en = 5'b00000; fl = 3'b011;
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_halt = 1;
      end
      m_stall++;
    end else if (busy) begin
      en = 5'b00000; fl = 3'b001; m_stall++;
    end else if (hz.branch_taken_ex) begin
      fl = 3'b110; m_flush++;
    end else if (lu) begin
      en = 5'b00111; fl = 3'b010; m_stall++;
    end else if (hz.halt_id) begin
      en = 5'b01111; fl = 3'b110; m_stall++; m_drain_left = 3;
    end
    exp = {en, fl};
  endtask

  // inputs already applied at a negedge; checks, advances model, returns at next negedge
  task automatic cycle(input string tag);
    logic [7:0] exp;
    bit exp_halt;
    longint exp_st, exp_fl;
    #1;
    exp_halt = m_halt; exp_st = m_stall; exp_fl = m_flush;
    model_step(exp);
    check({tag, ".ctl"}, {56'd0, hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                          hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush}, {56'd0, exp});
    check({tag, ".halted"}, {63'd0, hz.halted}, {63'd0, exp_halt});
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 64'(hz.stall_cnt), exp_st[63:0]);
    check({tag, ".flush_cnt"}, 64'(hz.flush_cnt), exp_fl[63:0]);
`endif
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ctl"}, {56'd0, hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                          hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush}, 64'h07);
    check({tag, ".halted"}, {63'd0, hz.halted}, 64'd0);
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 64'(hz.stall_cnt), 64'd0);
    check({tag, ".flush_cnt"}, 64'(hz.flush_cnt), 64'd0);
`endif
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // load-use stall, then rd_ex=0 must not stall
    hz.mem_read_ex = 1; hz.rd_ex = 5; hz.rs1_id = 5; hz.rs1_used_id = 1;
    cycle("lu");
    idle(); cycle("lu_after");
    hz.mem_read_ex = 1; hz.rd_ex = 0; hz.rs1_id = 0; hz.rs1_used_id = 1;
    cycle("lu_x0");
    // branch beats load-use
    hz.mem_read_ex = 1; hz.rd_ex = 7; hz.rs2_id = 7; hz.rs2_used_id = 1; hz.branch_taken_ex = 1;
    cycle("br_lu");
    idle(); cycle("br_after");
    // three wait states then completion
    hz.dmem_req_mem = 1;
    for (int i = 0; i < 3; i++) cycle("mwait");
    hz.dmem_ready_mem = 1; cycle("mdone");
    idle(); cycle("mafter");
    // halt, drain, hold, resume
    hz.halt_id = 1; cycle("halt");
    idle();
    for (int i = 0; i < 6; i++) cycle("drain_hold");
    hz.resume_req = 1; cycle("resume");
    idle(); cycle("run_again");
    // halt with a 2-cycle memory wait inside DRAIN
    hz.halt_id = 1; cycle("halt2");
    idle(); cycle("drain2");
    hz.dmem_req_mem = 1;
    cycle("drain_busy"); cycle("drain_busy");
    idle();
    for (int i = 0; i < 5; i++) cycle("drain2_end");
    hz.resume_req = 1; cycle("resume2");
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hz.rs1_id = 5'($urandom_range(0, 3));
      hz.rs2_id = 5'($urandom_range(0, 3));
      hz.rd_ex = 5'($urandom_range(0, 3));
      hz.rs1_used_id = 1'($urandom_range(0, 1));
      hz.rs2_used_id = 1'($urandom_range(0, 1));
      hz.mem_read_ex = 1'($urandom_range(0, 1));
      hz.branch_taken_ex = ($urandom_range(0, 5) == 0);
      hz.halt_id = ($urandom_range(0, 9) == 0);
      hz.resume_req = ($urandom_range(0, 3) == 0);
      hz.dmem_req_mem = ($urandom_range(0, 3) == 0);
      hz.dmem_ready_mem = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    // asynchronous reset while halted
    idle();
    hz.halt_id = 1; cycle("halt3");
    idle();
    for (int i = 0; i < 4; i++) cycle("drain3");
    check("halted_before_rst", {63'd0, hz.halted}, 64'd1);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
